// File: rtl/seg7_reader_pkg.sv
// seg7_pkg: segment pattern constants, FSM states and decode result for seg7_reader.
// SEG7_READER_DP_EN adds the active-low decimal point as bit 7 of the sampled segment word.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000011;
    localparam logic [6:0] SEG_6_ALT = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_9_ALT = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef SEG7_READER_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_e;
    typedef struct packed {
        logic [3:0] bcd;
        logic       legal;
        logic       blank;
    } dec_t;
endpackage

// File: rtl/seg7_reader_decode.sv
// seg7_pattern_decode: maps an active-low 7-segment pattern to its BCD value, legality and blank flag.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output dec_t       dec_o
);
    always_comb begin
        dec_o = '{bcd: 4'hF, legal: 1'b0, blank: 1'b0};
        case (seg_i)
            SEG_0:            dec_o = '{bcd: 4'd0, legal: 1'b1, blank: 1'b0};
            SEG_1:            dec_o = '{bcd: 4'd1, legal: 1'b1, blank: 1'b0};
            SEG_2:            dec_o = '{bcd: 4'd2, legal: 1'b1, blank: 1'b0};
            SEG_3:            dec_o = '{bcd: 4'd3, legal: 1'b1, blank: 1'b0};
            SEG_4:            dec_o = '{bcd: 4'd4, legal: 1'b1, blank: 1'b0};
            SEG_5:            dec_o = '{bcd: 4'd5, legal: 1'b1, blank: 1'b0};
            SEG_6, SEG_6_ALT: dec_o = '{bcd: 4'd6, legal: 1'b1, blank: 1'b0};
            SEG_7:            dec_o = '{bcd: 4'd7, legal: 1'b1, blank: 1'b0};
            SEG_8:            dec_o = '{bcd: 4'd8, legal: 1'b1, blank: 1'b0};
            SEG_9, SEG_9_ALT: dec_o = '{bcd: 4'd9, legal: 1'b1, blank: 1'b0};
            SEG_BLANK:        dec_o = '{bcd: 4'hF, legal: 1'b0, blank: 1'b1};
            default:          dec_o = '{bcd: 4'hF, legal: 1'b0, blank: 1'b0};
        endcase
    end
endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: recovers per-digit BCD values from a multiplexed 7-segment bus and reports changes as events.
// SEG7_READER_DP_EN adds the decimal point to the sample, the change detection and the DP_OUT port.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int NDIG   = 8,
    parameter int STABLE = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [NDIG-1:0]   DIG_SEL,
    input  logic [SEG_W-1:0]  SEG,
    output logic [4*NDIG-1:0] BCD_OUT,
    output logic [NDIG-1:0]   DIG_VALID,
    output logic [NDIG-1:0]   ERR,
    output logic              UPD_VALID,
    input  logic              UPD_READY,
    output logic [2:0]        UPD_IDX,
    output logic [3:0]        UPD_BCD,
    output logic              OVF
`ifdef SEG7_READER_DP_EN
   ,output logic [NDIG-1:0]   DP_OUT
`endif
);
    logic [NDIG-1:0]       sel_q;
    logic [SEG_W-1:0]      seg_q;
    logic [NDIG+SEG_W-1:0] prev_q;
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  commit, same, changed;
    dec_t                  dec;
    logic [4*NDIG-1:0]     bcd_q, bcd_d;
    logic [NDIG-1:0]       val_q, val_d, err_q, err_d;
    logic                  upd_valid_q, upd_valid_d, ovf_q, ovf_d;
    logic [2:0]            upd_idx_q, upd_idx_d, idx;
    logic [3:0]            upd_bcd_q, upd_bcd_d, cur_bcd, new_bcd;
    logic                  cur_v, cur_e, new_e;
`ifdef SEG7_READER_DP_EN
    logic [NDIG-1:0]       dp_q, dp_d;
    logic                  cur_dp;
`endif

    seg7_pattern_decode u_dec (.seg_i(seg_q[6:0]), .dec_o(dec));

    assign same = ({sel_q, seg_q} == prev_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!$onehot(sel_q)) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (state_q == IDLE || !same) begin
            state_d = TRACK;
            cnt_d   = 4'd1;
        end else if (state_q == TRACK) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == 4'(STABLE)) begin
                state_d = LOCKED;
                commit  = 1'b1;
            end
        end
    end

    // Commit writes only the strobed digit; an event fires only when its stored view changes.
    always_comb begin
        idx     = 3'd0;
        cur_bcd = 4'hF;
        cur_v   = 1'b0;
        cur_e   = 1'b0;
        new_bcd = dec.legal ? dec.bcd : 4'hF;
        new_e   = !dec.legal && !dec.blank;
        bcd_d   = bcd_q;
        val_d   = val_q;
        err_d   = err_q;
`ifdef SEG7_READER_DP_EN
        cur_dp  = 1'b0;
        dp_d    = dp_q;
`endif
        for (int i = 0; i < NDIG; i++) begin
            if (sel_q[i]) begin
                idx     = 3'(i);
                cur_bcd = bcd_q[4*i +: 4];
                cur_v   = val_q[i];
                cur_e   = err_q[i];
`ifdef SEG7_READER_DP_EN
                cur_dp  = dp_q[i];
`endif
                if (commit) begin
                    bcd_d[4*i +: 4] = new_bcd;
                    val_d[i]        = dec.legal;
                    err_d[i]        = new_e;
`ifdef SEG7_READER_DP_EN
                    dp_d[i]         = ~seg_q[7];
`endif
                end
            end
        end
`ifdef SEG7_READER_DP_EN
        changed = commit && ({new_bcd, dec.legal, new_e, ~seg_q[7]} != {cur_bcd, cur_v, cur_e, cur_dp});
`else
        changed = commit && ({new_bcd, dec.legal, new_e} != {cur_bcd, cur_v, cur_e});
`endif
        upd_valid_d = changed || (upd_valid_q && !UPD_READY);
        upd_idx_d   = changed ? idx : upd_idx_q;
        upd_bcd_d   = changed ? new_bcd : upd_bcd_q;
        ovf_d       = ovf_q || (changed && upd_valid_q && !UPD_READY);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sel_q       <= '0;
            seg_q       <= '1;
            prev_q      <= {{NDIG{1'b0}}, {SEG_W{1'b1}}};
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            bcd_q       <= '1;
            val_q       <= '0;
            err_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= 3'd0;
            upd_bcd_q   <= 4'd0;
            ovf_q       <= 1'b0;
`ifdef SEG7_READER_DP_EN
            dp_q        <= '0;
`endif
        end else begin
            sel_q       <= DIG_SEL;
            seg_q       <= SEG;
            prev_q      <= {sel_q, seg_q};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            val_q       <= val_d;
            err_q       <= err_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_bcd_q   <= upd_bcd_d;
            ovf_q       <= ovf_d;
`ifdef SEG7_READER_DP_EN
            dp_q        <= dp_d;
`endif
        end
    end

    assign BCD_OUT   = bcd_q;
    assign DIG_VALID = val_q;
    assign ERR       = err_q;
    assign UPD_VALID = upd_valid_q;
    assign UPD_IDX   = upd_idx_q;
    assign UPD_BCD   = upd_bcd_q;
    assign OVF       = ovf_q;
`ifdef SEG7_READER_DP_EN
    assign DP_OUT    = dp_q;
`endif
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed vectors and hand-written sequences for seg7_reader with NDIG=8, STABLE=4.
module tb_seg7_reader;
    typedef struct {
        logic [7:0] sel;
        logic [6:0] seg;
        logic [3:0] bcd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [7:0]  sel;
    logic [6:0]  seg;
    logic [31:0] bcd_out;
    logic [7:0]  dig_valid, err;
    logic        upd_valid, ovf;
    logic [2:0]  upd_idx;
    logic [3:0]  upd_bcd;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  m_bcd [8];
    logic [7:0]  m_v, m_e;
    vec_t        tbl [8];

    always #5 clk = ~clk;

    seg7_reader #(.NDIG(8), .STABLE(4)) dut (
        .CLOCK_50(clk), .RESET(rst), .DIG_SEL(sel), .SEG(seg),
        .BCD_OUT(bcd_out), .DIG_VALID(dig_valid), .ERR(err),
        .UPD_VALID(upd_valid), .UPD_READY(rdy), .UPD_IDX(upd_idx),
        .UPD_BCD(upd_bcd), .OVF(ovf)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] p;
        for (int i = 0; i < 8; i++) p[4*i +: 4] = m_bcd[i];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_bcd[i] = 4'hF;
        m_v = '0;
        m_e = '0;
    endtask

    task automatic model_set(input logic [7:0] s, input logic [3:0] b, input logic e);
        for (int i = 0; i < 8; i++) begin
            if (s[i]) begin
                m_bcd[i] = b;
                m_v[i]   = (b != 4'hF);
                m_e[i]   = e;
            end
        end
    endtask

    task automatic chk_regs(input string nm);
        chk({nm, "_bcd_out"}, bcd_out, m_pack());
        chk({nm, "_dig_valid"}, {24'd0, dig_valid}, {24'd0, m_v});
        chk({nm, "_err"}, {24'd0, err}, {24'd0, m_e});
    endtask

    task automatic ack();
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        chk("ack_clear", upd_valid, 0);
    endtask

    // Hold a pattern through the filter; expects no commit at k+3 and the commit at k+4.
    task automatic apply(input logic [7:0] s, input logic [6:0] g, input logic [3:0] b,
                         input logic e, input logic ev, input string nm);
        int idx;
        idx = 0;
        sel = s;
        seg = g;
        tick(4);
        chk({nm, "_early"}, upd_valid, 0);
        tick(1);
        for (int i = 0; i < 8; i++) if (s[i]) idx = i;
        model_set(s, b, e);
        chk_regs(nm);
        chk({nm, "_ev"}, upd_valid, ev);
        if (ev) begin
            chk({nm, "_idx"}, upd_idx, idx);
            chk({nm, "_upd_bcd"}, upd_bcd, b);
            ack();
        end
    endtask

    initial begin
        tbl[0] = '{8'h01, 7'b1000000, 4'd0};
        tbl[1] = '{8'h02, 7'b1111001, 4'd1};
        tbl[2] = '{8'h04, 7'b0100100, 4'd2};
        tbl[3] = '{8'h08, 7'b0110000, 4'd3};
        tbl[4] = '{8'h10, 7'b0000011, 4'd6};
        tbl[5] = '{8'h20, 7'b0010010, 4'd5};
        tbl[6] = '{8'h40, 7'b0010000, 4'd9};
        tbl[7] = '{8'h80, 7'b1111000, 4'd7};
        rst = 1'b1;
        rdy = 1'b0;
        sel = 8'h01;
        seg = 7'b0110000;
        model_reset();
        tick(2);
        chk_regs("reset");
        chk("reset_upd_valid", upd_valid, 0);
        chk("reset_upd_idx", upd_idx, 0);
        chk("reset_upd_bcd", upd_bcd, 0);
        chk("reset_ovf", ovf, 0);
        rst = 1'b0;
        apply(8'h01, 7'b0110000, 4'd3, 1'b0, 1'b1, "release");
        // glitch to 7 for two samples inside a stable 8 on digit 2
        sel = 8'h04;
        seg = 7'b0000000;
        tick(2);
        chk("glitch_a", upd_valid, 0);
        seg = 7'b1111000;
        tick(2);
        chk("glitch_b", upd_valid, 0);
        chk_regs("glitch_b");
        seg = 7'b0000000;
        tick(3);
        chk("glitch_c", upd_valid, 0);
        chk_regs("glitch_c");
        tick(1);
        chk("glitch_d", upd_valid, 0);
        tick(1);
        model_set(8'h04, 4'd8, 1'b0);
        chk_regs("glitch_commit");
        chk("glitch_ev", upd_valid, 1);
        chk("glitch_idx", upd_idx, 2);
        chk("glitch_upd_bcd", upd_bcd, 8);
        // pending event held, then handshake on the same edge as a new commit
        sel = 8'h01;
        seg = 7'b0011000;
        tick(4);
        chk("hold_valid", upd_valid, 1);
        chk("hold_idx", upd_idx, 2);
        chk("hold_bcd", upd_bcd, 8);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        model_set(8'h01, 4'd9, 1'b0);
        chk_regs("same_edge");
        chk("same_edge_valid", upd_valid, 1);
        chk("same_edge_idx", upd_idx, 0);
        chk("same_edge_bcd", upd_bcd, 9);
        chk("same_edge_ovf", ovf, 0);
        ack();
        // overwrite without handshake
        sel = 8'h02;
        seg = 7'b0011001;
        tick(5);
        model_set(8'h02, 4'd4, 1'b0);
        chk("ovf1_valid", upd_valid, 1);
        chk("ovf1_idx", upd_idx, 1);
        chk("ovf1_bcd", upd_bcd, 4);
        chk("ovf1_ovf", ovf, 0);
        sel = 8'h08;
        seg = 7'b1111000;
        tick(5);
        model_set(8'h08, 4'd7, 1'b0);
        chk_regs("ovf2");
        chk("ovf2_valid", upd_valid, 1);
        chk("ovf2_idx", upd_idx, 3);
        chk("ovf2_bcd", upd_bcd, 7);
        chk("ovf2_ovf", ovf, 1);
        ack();
        chk("ovf_sticky", ovf, 1);
        // all digits twice: first pass changes every digit, second pass is silent
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 8; i++)
                apply(tbl[i].sel, tbl[i].seg, tbl[i].bcd, 1'b0, (p == 0), $sformatf("cyc%0d_%0d", p, i));
        apply(8'h20, 7'b0100101, 4'hF, 1'b1, 1'b1, "illegal");
        apply(8'h20, 7'b1111111, 4'hF, 1'b0, 1'b1, "blank");
        // multiple strobes set: nothing is accepted
        sel = 8'h03;
        seg = 7'b1111001;
        tick(8);
        chk_regs("idle");
        chk("idle_ev", upd_valid, 0);
        // asynchronous reset while locked, then recommit after release
        apply(8'h04, 7'b0010010, 4'd5, 1'b0, 1'b1, "pre_rst");
        tick(2);
        rst = 1'b1;
        #1;
        model_reset();
        chk_regs("async_rst");
        chk("async_rst_valid", upd_valid, 0);
        chk("async_rst_idx", upd_idx, 0);
        chk("async_rst_bcd", upd_bcd, 0);
        chk("async_rst_ovf", ovf, 0);
        tick(1);
        rst = 1'b0;
        apply(8'h04, 7'b0010010, 4'd5, 1'b0, 1'b1, "post_rst");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
